// File: rtl/spi_cmd_terminal.sv
// spi_cmd_terminal: takes parity-checked command words from the SPI slave and
// executes them against a small register file. It then returns exactly one
// reply word through the SPI master. A status command reports the error and
// command counters, and a reply that the master never picks up ends in a
// timeout.
module spi_cmd_terminal #(
    parameter int  DATA_W  = 64,
    parameter int  NREGS   = 16,
    parameter int  TIMEOUT = 1024,
    localparam int PW      = DATA_W - 13,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              RX_VALID,
    input  logic [DATA_W-1:0] RX_DATA,
    output logic              RX_RD,
    input  logic              TX_BUSY,
    output logic              TX_WR,
    output logic [DATA_W-1:0] TX_DATA,
    input  logic [AW-1:0]     REG_SEL,
    output logic [PW-1:0]     REG_Q,
    output logic              UPD,
    output logic [AW-1:0]     UPD_ADDR,
    output logic [15:0]       ERR_CNT,
    output logic [15:0]       RX_CNT
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [3:0] OP_WRITE  = 4'h1;
    localparam logic [3:0] OP_READ   = 4'h2;
    localparam logic [3:0] OP_ECHO   = 4'h3;
    localparam logic [3:0] OP_STATUS = 4'h4;
    localparam logic [3:0] OP_ERROR  = 4'hE;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_PARITY = 2'd1;
    localparam logic [1:0] ERR_OPCODE = 2'd2;
    localparam logic [1:0] ERR_ADDR   = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, SEND, WAIT} state_t;

    state_t              state;
    state_t              state_nx;
    logic [DATA_W-1:0]   cmd;
    logic [PW-1:0]       regs [NREGS];
    logic [TW-1:0]       timer;

    logic [3:0]          cmd_op;
    logic [7:0]          cmd_addr;
    logic [PW-1:0]       cmd_pl;
    logic                addr_ok;
    logic [PW-1:0]       rd_val;
    logic [1:0]          err_code;
    logic [3:0]          rep_op;
    logic [PW-1:0]       rep_pl;
    logic [DATA_W-2:0]   rep_body;
    logic [DATA_W-1:0]   reply;
    logic                capture;
    logic                launch;
    logic                timeout_hit;
    logic                do_write;
    logic                err_inc;

    assign cmd_op   = cmd[DATA_W-1 -: 4];
    assign cmd_addr = cmd[DATA_W-5 -: 8];
    assign cmd_pl   = cmd[DATA_W-13:1];
    assign reply    = {rep_body, ^rep_body};

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state: one command at a time, RX_VALID only looked at in IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (RX_VALID) state_nx = EXEC;
            EXEC:    state_nx = SEND;
            SEND:    if (!TX_BUSY) state_nx = WAIT;
            WAIT:    if (TX_BUSY || timeout_hit) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Decode the captured command and build the reply and the control strobes
    always_comb begin
        capture     = (state == IDLE) && RX_VALID;
        launch      = (state == SEND) && !TX_BUSY;
        timeout_hit = (state == WAIT) && !TX_BUSY && (timer == TW'(TIMEOUT - 1));
        addr_ok     = int'(cmd_addr) < NREGS;
        rd_val      = addr_ok ? regs[cmd_addr[AW-1:0]] : '0;

        err_code = ERR_NONE;
        if (^cmd)
            err_code = ERR_PARITY;
        else if (cmd_op == 4'h0 || cmd_op > OP_STATUS)
            err_code = ERR_OPCODE;
        else if ((cmd_op == OP_WRITE || cmd_op == OP_READ) && !addr_ok)
            err_code = ERR_ADDR;

        rep_op = cmd_op;
        rep_pl = '0;
        if (err_code != ERR_NONE) begin
            rep_op = OP_ERROR;
            rep_pl = PW'(err_code);
        end else begin
            case (cmd_op)
                OP_WRITE:  rep_pl = cmd_pl;
                OP_READ:   rep_pl = rd_val;
                OP_ECHO:   rep_pl = cmd_pl;
                OP_STATUS: rep_pl = PW'({ERR_CNT, RX_CNT});
                default:   rep_pl = '0;
            endcase
        end
        rep_body = {rep_op, cmd_addr, rep_pl};

        do_write = (state == EXEC) && (err_code == ERR_NONE) && (cmd_op == OP_WRITE);
        err_inc  = ((state == EXEC) && (err_code != ERR_NONE)) || timeout_hit;
    end

    // Datapath: capture, register file, reply word, pulses, counters, timeout timer
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cmd      <= '0;
            TX_DATA  <= '0;
            RX_RD    <= 1'b0;
            TX_WR    <= 1'b0;
            UPD      <= 1'b0;
            UPD_ADDR <= '0;
            ERR_CNT  <= '0;
            RX_CNT   <= '0;
            timer    <= '0;
            for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            RX_RD <= capture;
            TX_WR <= launch;
            UPD   <= do_write;
            if (capture) begin
                cmd <= RX_DATA;
                if (RX_CNT != '1) RX_CNT <= RX_CNT + 16'd1;
            end
            if (state == EXEC) TX_DATA <= reply;
            if (do_write) begin
                regs[cmd_addr[AW-1:0]] <= cmd_pl;
                UPD_ADDR               <= cmd_addr[AW-1:0];
            end
            if (err_inc && ERR_CNT != '1) ERR_CNT <= ERR_CNT + 16'd1;
            if (launch)             timer <= '0;
            else if (state == WAIT) timer <= timer + TW'(1);
        end
    end

    // Host-side readback; selects beyond the file read as zero
    always_comb begin
        REG_Q = '0;
        if (int'(REG_SEL) < NREGS) REG_Q = regs[REG_SEL];
    end

endmodule

// File: tb/tb_spi_cmd_terminal.sv
// tb_spi_cmd_terminal: runs directed and random commands into spi_cmd_terminal.
// Expected replies come from a reference model of the command rules and go
// into a scoreboard queue. A monitor compares them whenever TX_WR pulses.
module tb_spi_cmd_terminal;
    localparam int DATA_W  = 32;
    localparam int NREGS   = 16;
    localparam int TIMEOUT = 1024;
    localparam int PW      = DATA_W - 13;
    localparam int AW      = 4;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              RX_VALID = 1'b0;
    logic [DATA_W-1:0] RX_DATA = '0;
    logic              RX_RD;
    logic              TX_BUSY = 1'b0;
    logic              TX_WR;
    logic [DATA_W-1:0] TX_DATA;
    logic [AW-1:0]     REG_SEL = '0;
    logic [PW-1:0]     REG_Q;
    logic              UPD;
    logic [AW-1:0]     UPD_ADDR;
    logic [15:0]       ERR_CNT;
    logic [15:0]       RX_CNT;

    int checks = 0;
    int failures = 0;

    // model state
    int unsigned regs_m [NREGS];
    int rx_cnt = 0;
    int err_cnt = 0;
    logic [DATA_W-1:0] exp_q [$];
    logic [AW-1:0]     upd_q [$];

    spi_cmd_terminal #(.DATA_W(DATA_W), .NREGS(NREGS), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .RX_RD(RX_RD),
        .TX_BUSY(TX_BUSY), .TX_WR(TX_WR), .TX_DATA(TX_DATA),
        .REG_SEL(REG_SEL), .REG_Q(REG_Q),
        .UPD(UPD), .UPD_ADDR(UPD_ADDR),
        .ERR_CNT(ERR_CNT), .RX_CNT(RX_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int op, input int addr, input int unsigned pl, input bit bad);
        logic [DATA_W-1:0] w;
        w = {4'(op), 8'(addr), PW'(pl), 1'b0};
        w[0] = 1'($countones(w) % 2);
        if (bad) w[0] = ~w[0];
        return w;
    endfunction

    // Reference model: applies the command rules and returns the reply word
    function automatic logic [DATA_W-1:0] model_cmd(input logic [DATA_W-1:0] w, output bit wr);
        int op, a, code;
        int unsigned pl, rp;
        int rop;
        logic [DATA_W-1:0] r;
        op = int'(w[31:28]);
        a  = int'(w[27:20]);
        pl = w[19:1];
        wr = 0;
        code = 0;
        rp = 0;
        if (rx_cnt < 65535) rx_cnt++;
        if ($countones(w) % 2 != 0) code = 1;
        else if (op == 0 || op > 4) code = 2;
        else if ((op == 1 || op == 2) && a >= NREGS) code = 3;
        if (code != 0) begin
            rop = 14;
            rp = code;
            if (err_cnt < 65535) err_cnt++;
        end else begin
            rop = op;
            case (op)
                1: begin regs_m[a] = pl; rp = pl; wr = 1; upd_q.push_back(AW'(a)); end
                2: rp = regs_m[a];
                3: rp = pl;
                default: rp = (err_cnt * 65536 + rx_cnt) % (1 << PW);
            endcase
        end
        r = {4'(rop), 8'(a), PW'(rp), 1'b0};
        r[0] = 1'($countones(r) % 2);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) regs_m[i] = 0;
        rx_cnt = 0;
        err_cnt = 0;
        exp_q.delete();
        upd_q.delete();
    endfunction

    // Monitor: every TX_WR pulse must match the oldest expected reply; every UPD the oldest write
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (TX_WR) begin
                if (exp_q.size() == 0) chk("tx_unexpected", 64'(TX_DATA), 64'hDEAD_0000_0000);
                else chk("tx_data", 64'(TX_DATA), 64'(exp_q.pop_front()));
            end
            if (UPD) begin
                if (upd_q.size() == 0) chk("upd_unexpected", 64'(UPD_ADDR), 64'hDEAD_0000_0000);
                else chk("upd_addr", 64'(UPD_ADDR), 64'(upd_q.pop_front()));
            end
        end
    end

    // mode 0: normal; 1: TX_BUSY held high 50 cycles through SEND; 2: master never answers
    task automatic do_cmd(input logic [DATA_W-1:0] w, input int mode);
        bit wr;
        bit seen;
        int n;
        logic [15:0] prev;
        exp_q.push_back(model_cmd(w, wr));
        if (mode == 1) TX_BUSY = 1'b1;
        RX_DATA = w;
        RX_VALID = 1'b1;
        n = 0;
        while (!RX_RD && n < 20) begin @(negedge CLK); n++; end
        chk("rx_rd_seen", 64'(RX_RD), 64'd1);
        RX_VALID = 1'b0;
        @(negedge CLK);
        chk("rx_rd_pulse", 64'(RX_RD), 64'd0);
        chk("upd_timing", 64'(UPD), 64'(wr));
        if (mode == 1) begin
            seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge CLK);
                if (TX_WR) seen = 1;
            end
            chk("busy_hold_no_wr", 64'(seen), 64'd0);
            TX_BUSY = 1'b0;
            @(negedge CLK);
            chk("wr_after_busy", 64'(TX_WR), 64'd1);
        end else begin
            n = 1;
            while (!TX_WR && n < 2000) begin @(negedge CLK); n++; end
            chk("tx_latency", 64'(n), 64'd2);
        end
        if (mode == 2) begin
            prev = ERR_CNT;
            n = 0;
            while (ERR_CNT == prev && n < 2000) begin @(negedge CLK); n++; end
            chk("timeout_cycles", 64'(n), 64'(TIMEOUT));
            if (err_cnt < 65535) err_cnt++;
        end else begin
            TX_BUSY = 1'b1;
            repeat (3) @(negedge CLK);
            TX_BUSY = 1'b0;
            @(negedge CLK);
        end
        chk("rx_cnt", 64'(RX_CNT), 64'(rx_cnt));
        chk("err_cnt", 64'(ERR_CNT), 64'(err_cnt));
        REG_SEL = AW'(w[27:20]);
        #1;
        chk("reg_q", 64'(REG_Q), 64'(regs_m[REG_SEL]));
    endtask

    task automatic chk_reset_values();
        chk("rst_rx_rd", 64'(RX_RD), 64'd0);
        chk("rst_tx_wr", 64'(TX_WR), 64'd0);
        chk("rst_upd", 64'(UPD), 64'd0);
        chk("rst_tx_data", 64'(TX_DATA), 64'd0);
        chk("rst_upd_addr", 64'(UPD_ADDR), 64'd0);
        chk("rst_err_cnt", 64'(ERR_CNT), 64'd0);
        chk("rst_rx_cnt", 64'(RX_CNT), 64'd0);
        chk("rst_reg_q", 64'(REG_Q), 64'd0);
    endtask

    initial begin
        int op, addr;
        model_reset();
        REG_SEL = 4'd3;
        #12;
        chk_reset_values();
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // directed: write/read, error priority, busy hold, timeout
        do_cmd(mk(1, 3, 32'h12345, 0), 0);
        do_cmd(mk(2, 3, 0, 0), 0);
        do_cmd(mk(2, 5, 0, 0), 0);
        do_cmd(mk(1, 3, 32'h0ABCD, 1), 0);
        do_cmd(mk(7, 3, 32'h0ABCD, 0), 0);
        do_cmd(mk(2, 20, 0, 0), 0);
        do_cmd(mk(9, 20, 0, 1), 0);
        do_cmd(mk(3, 0, 32'h7FFFF, 0), 1);
        do_cmd(mk(4, 0, 0, 0), 2);
        do_cmd(mk(2, 3, 0, 0), 0);

        // random commands
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 1;
                2, 3:    op = 2;
                4:       op = 3;
                5:       op = 4;
                default: op = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 15));
            endcase
            if ($urandom_range(0, 9) == 0 && op != 0 && op < 5) op = int'($urandom_range(0, 3));
            addr = int'($urandom_range(0, 19));
            do_cmd(mk(op, addr, $urandom, $urandom_range(0, 7) == 0), 0);
        end

        // reset in the middle of SEND abandons the pending reply
        do_cmd(mk(1, 3, 32'h55555, 0), 0);
        do_cmd(mk(1, 7, 32'h00001, 0), 0);
        TX_BUSY = 1'b1;
        RX_DATA = mk(2, 3, 0, 0);
        RX_VALID = 1'b1;
        begin
            int n = 0;
            while (!RX_RD && n < 20) begin @(negedge CLK); n++; end
        end
        RX_VALID = 1'b0;
        repeat (5) @(negedge CLK);
        #2 RESET_N = 1'b0;
        REG_SEL = 4'd3;
        #1;
        chk_reset_values();
        model_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        TX_BUSY = 1'b0;
        repeat (3) @(negedge CLK);

        // status after a mix of good and bad commands
        do_cmd(mk(1, 1, 32'h00777, 0), 0);
        do_cmd(mk(2, 1, 0, 1), 0);
        do_cmd(mk(2, 1, 0, 0), 0);
        do_cmd(mk(0, 1, 0, 0), 0);
        do_cmd(mk(3, 9, 32'h4321F, 0), 0);
        do_cmd(mk(4, 0, 0, 0), 0);

        repeat (5) @(negedge CLK);
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("upd_q_drained", 64'(upd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
